// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits + odd parity, ACK check, timeout.
// Define PS2_TX_FILTER_EN to add an 8-sample glitch filter on the synchronized PS/2 clock.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ICW-1:0] INH_LAST = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [ICW-1:0] DATA_AT  = ICW'((INHIBIT_CYCLES > 100) ? INHIBIT_CYCLES - 101 : 0);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    XFER,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   sclk, sdat;
  logic                   clk_lvl, lvl_prev, fall;

  logic [ICW-1:0] inh_cnt, inh_cnt_n;
  logic [TCW-1:0] to_cnt, to_cnt_n;
  logic [7:0]     shift, shift_n;
  logic           parity, parity_n;
  logic [3:0]     bitcnt, bitcnt_n;
  logic           fail, fail_n;
  logic           idle_seen, idle_seen_n;
  logic           clk_oe_n, data_oe_n, done_n, err_n;
  logic [1:0]     code_n;
  logic           timeout;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
    end
  end

  assign sclk = clk_sync[SYNC_STAGES-1];
  assign sdat = data_sync[SYNC_STAGES-1];

`ifdef PS2_TX_FILTER_EN
  logic       filt_lvl;
  logic [2:0] filt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
    end else if (sclk == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_cnt == 3'd7) begin
      filt_lvl <= sclk;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 3'd1;
    end
  end

  assign clk_lvl = filt_lvl;
`else
  assign clk_lvl = sclk;
`endif

  always_ff @(posedge clk) begin
    if (rst) lvl_prev <= 1'b1;
    else     lvl_prev <= clk_lvl;
  end

  assign fall = lvl_prev & ~clk_lvl;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign timeout  = (to_cnt == TO_LAST);

  always_comb begin
    state_n     = state;
    inh_cnt_n   = inh_cnt;
    to_cnt_n    = to_cnt;
    shift_n     = shift;
    parity_n    = parity;
    bitcnt_n    = bitcnt;
    fail_n      = fail;
    idle_seen_n = idle_seen;
    clk_oe_n    = ps2_clk_oe;
    data_oe_n   = ps2_data_oe;
    done_n      = 1'b0;
    err_n       = 1'b0;
    code_n      = err_code;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_n   = tx_data;
          parity_n  = ~^tx_data;
          bitcnt_n  = '0;
          inh_cnt_n = '0;
          fail_n    = 1'b0;
          code_n    = 2'b00;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          state_n   = INHIBIT;
        end
      end

      INHIBIT: begin
        inh_cnt_n = inh_cnt + ICW'(1);
        if (inh_cnt == DATA_AT) data_oe_n = 1'b1;
        if (inh_cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          to_cnt_n  = '0;
          state_n   = XFER;
        end
      end

      XFER: begin
        to_cnt_n = to_cnt + TCW'(1);
        if (fall) begin
          bitcnt_n = bitcnt + 4'd1;
          if (bitcnt < 4'd8) begin
            data_oe_n = ~shift[bitcnt[2:0]];
          end else if (bitcnt == 4'd8) begin
            data_oe_n = ~parity;
          end else begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end
        end
      end

      ACK: begin
        to_cnt_n = to_cnt + TCW'(1);
        if (fall) begin
          if (sdat) begin
            fail_n = 1'b1;
            code_n = 2'b10;
          end
          idle_seen_n = 1'b0;
          state_n     = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        to_cnt_n    = to_cnt + TCW'(1);
        idle_seen_n = sclk & sdat;
        if (sclk && sdat && idle_seen) begin
          state_n = IDLE;
          if (fail) err_n  = 1'b1;
          else      done_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    // Timeout overrides whatever the active state decided, including a same-cycle completion.
    if ((state == XFER || state == ACK || state == WAIT_IDLE) && timeout) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      code_n    = 2'b01;
      done_n    = 1'b0;
      err_n     = 1'b1;
      state_n   = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      bitcnt      <= '0;
      fail        <= 1'b0;
      idle_seen   <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      to_cnt      <= to_cnt_n;
      shift       <= shift_n;
      parity      <= parity_n;
      bitcnt      <= bitcnt_n;
      fail        <= fail_n;
      idle_seen   <= idle_seen_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_done     <= done_n;
      tx_err      <= err_n;
      err_code    <= code_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, PS/2 device model and result/frame scoreboards.
module tb_ps2_host_tx;

  localparam int unsigned INH   = 300;
  localparam int unsigned TO    = 4000;
  localparam int          HP    = 40;
  localparam int          LIMIT = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [8:0] bq[$];
  logic [2:0] rq[$];

  localparam logic [2:0] RES_OK    = 3'b0_00;
  localparam logic [2:0] RES_NOACK = 3'b1_10;
  localparam logic [2:0] RES_TO    = 3'b1_01;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .err_code   (err_code),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   hi_cnt = 0;
  int   xfer_cyc = 0;
  logic prev_coe = 1'b0;
  logic prev_doe = 1'b0;
  logic [2:0] exp_res;

  // Monitor: inhibit timing, and every done/err pulse is matched against the result queue.
  always @(negedge clk) begin
    if (rst) begin
      hi_cnt = 0;
    end else begin
      if (ps2_clk_oe) begin
        hi_cnt++;
        if (ps2_data_oe && !prev_doe) begin
          checks++;
          if (hi_cnt != INH - 99) begin
            errors++;
            $display("FAIL data_oe_rise: at clk_oe cycle %0d, required %0d", hi_cnt, INH - 99);
          end
        end
      end else if (prev_coe) begin
        checks++;
        if (hi_cnt != INH) begin
          errors++;
          $display("FAIL clk_oe_width: got %0d cycles, required %0d", hi_cnt, INH);
        end
        hi_cnt   = 0;
        xfer_cyc = cyc;
      end
      if (tx_done || tx_err) begin
        checks++;
        if (tx_done && tx_err) begin
          errors++;
          $display("FAIL done_err_same_cycle: done=%b err=%b, required one-hot", tx_done, tx_err);
        end else if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: done=%b err=%b code=%b, required no pulse", tx_done, tx_err, err_code);
        end else begin
          exp_res = rq.pop_front();
          if ({tx_err, err_code} !== exp_res || tx_done !== ~exp_res[2] ||
              ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL result: err=%b code=%b done=%b oe=%b%b, required err=%b code=%b done=%b oe=00",
                     tx_err, err_code, tx_done, ps2_clk_oe, ps2_data_oe, exp_res[2], exp_res[1:0], ~exp_res[2]);
          end
        end
      end
    end
    prev_coe = ps2_clk_oe;
    prev_doe = ps2_data_oe;
  end

  task automatic send_byte(input logic [7:0] d, input logic track, input logic [2:0] res);
    int n = 0;
    while (tx_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL ready_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
      return;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    bq.push_back({~^d, d});
    if (track) rq.push_back(res);
    @(negedge clk);
    tx_valid = 1'b0;
    if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b ready=%b, required busy=1 ready=0", tx_busy, tx_ready);
    end
  endtask

  // Device model: waits for the request, clocks 11 falls, samples bits in the low phase.
  task automatic device_xfer(input logic ack, input int abort_at, input logic glitch,
                             output logic [8:0] bits);
    int n;
    logic [8:0] exp;
    bits = '0;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    while (ps2_clk_oe !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL request_wait: clk_oe=%b after %0d cycles, required a request", ps2_clk_oe, n);
      return;
    end
    if (ps2_data_in !== 1'b0) begin
      errors++;
      $display("FAIL start_bit: data line=%b, required 0", ps2_data_in);
    end
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HP - 1) @(negedge clk);
      if (k <= 9) bits[k-1] = ps2_data_in;
      if (k == 10) begin
        checks++;
        if (ps2_data_oe !== 1'b0) begin
          errors++;
          $display("FAIL stop_release: data_oe=%b, required 0", ps2_data_oe);
        end
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1 || err_code !== 2'b00) begin
          errors++;
          $display("FAIL mid_reset: oe=%b%b ready=%b code=%b, required oe=00 ready=1 code=00",
                   ps2_clk_oe, ps2_data_oe, tx_ready, err_code);
        end
        if (bq.size() != 0) exp = bq.pop_front();
        return;
      end
      @(negedge clk);
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
      if (glitch && k >= 1 && k <= 9) begin
        repeat (15) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HP - 18) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
    end
    checks++;
    if (bq.size() == 0) begin
      errors++;
      $display("FAIL frame_missing: got %h, required a queued frame", bits);
    end else begin
      exp = bq.pop_front();
      if (bits !== exp) begin
        errors++;
        $display("FAIL frame: got %h, required %h", bits, exp);
      end
    end
  endtask

  task automatic check_results_drained(input string name);
    repeat (20) @(negedge clk);
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL %s_result_missing: %0d outcomes pending, required 0", name, rq.size());
      rq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 ||
        tx_done !== 1'b0 || tx_err !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b oe=%b%b done=%b err=%b code=%b, required 1 0 00 0 0 00",
               tx_ready, tx_busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err, err_code);
    end
  endtask

  task automatic test_send_ed();
    logic [8:0] b;
    send_byte(8'hED, 1'b1, RES_OK);
    device_xfer(1'b1, 0, 1'b0, b);
    checks++;
    if (b !== 9'h1ED) begin
      errors++;
      $display("FAIL ed_bits: got %b, required %b", b, 9'h1ED);
    end
    check_results_drained("ed");
  endtask

  task automatic test_back_to_back();
    logic [8:0] b1, b2;
    fork
      begin
        send_byte(8'h01, 1'b1, RES_OK);
        repeat (500) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_mid_xfer: tx_ready=%b, required 0", tx_ready);
        end
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        send_byte(8'hFF, 1'b1, RES_OK);
      end
      begin
        device_xfer(1'b1, 0, 1'b0, b1);
        device_xfer(1'b1, 0, 1'b0, b2);
      end
    join
    checks++;
    if (b1 !== 9'h001 || b2 !== 9'h1FF) begin
      errors++;
      $display("FAIL b2b_bits: got %h %h, required 001 1ff", b1, b2);
    end
    check_results_drained("b2b");
  endtask

  task automatic test_no_ack();
    logic [8:0] b;
    send_byte(8'h3C, 1'b1, RES_NOACK);
    device_xfer(1'b0, 0, 1'b0, b);
    check_results_drained("noack");
  endtask

  task automatic test_timeout();
    int n;
    logic pd;
    logic [8:0] junk;
    send_byte(8'h5A, 1'b1, RES_TO);
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    while (ps2_clk_oe !== 1'b0 && n < LIMIT) begin @(negedge clk); n++; end
    n = 0;
    pd = ps2_data_oe;
    while (tx_err !== 1'b1 && n < int'(TO) + 100) begin
      pd = ps2_data_oe;
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_wait: tx_err=%b after %0d cycles, required 1", tx_err, n);
    end else if (cyc - xfer_cyc != int'(TO) || pd !== 1'b1 || ps2_data_oe !== 1'b0 ||
                 ps2_clk_oe !== 1'b0 || err_code !== 2'b01) begin
      errors++;
      $display("FAIL timeout: delay=%0d prev_doe=%b oe=%b%b code=%b, required %0d 1 00 01",
               cyc - xfer_cyc, pd, ps2_clk_oe, ps2_data_oe, err_code, TO);
    end
    if (bq.size() != 0) junk = bq.pop_front();
    check_results_drained("timeout");
  endtask

  task automatic test_mid_reset();
    logic [8:0] b;
    send_byte(8'h96, 1'b0, RES_OK);
    device_xfer(1'b1, 5, 1'b0, b);
    repeat (HP) @(negedge clk);
    send_byte(8'h00, 1'b1, RES_OK);
    device_xfer(1'b1, 0, 1'b0, b);
    checks++;
    if (b !== 9'h100) begin
      errors++;
      $display("FAIL after_reset_bits: got %h, required 100", b);
    end
    check_results_drained("reset");
  endtask

`ifdef PS2_TX_FILTER_EN
  task automatic test_glitch_filter();
    logic [8:0] b;
    send_byte(8'hED, 1'b1, RES_OK);
    device_xfer(1'b1, 0, 1'b1, b);
    checks++;
    if (b !== 9'h1ED) begin
      errors++;
      $display("FAIL glitch_bits: got %b, required %b", b, 9'h1ED);
    end
    check_results_drained("glitch");
  endtask
`endif

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog: simulation exceeded its time limit, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_no_ack();
    test_timeout();
    test_mid_reset();
`ifdef PS2_TX_FILTER_EN
    test_glitch_filter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
